intersection_monitor: RTL and testbench
=======================================

# intersection_monitor

Passive checker on the six-lamp output bus of the intersection controller. It samples the NS/EW red/yellow/green lamp lines and decodes them into a phase. It checks each phase against the legal sequence and the nominal phase durations, and raises a sticky, coded fault on any violation. It sits beside the controller and feeds the supervisor/fail-safe logic; it never drives lamps.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- GREEN_RED_ms, 200: nominal green phase duration in ms.
- YELLOW_ms, 40: nominal yellow phase duration in ms.
- TOL_CYCLES, 16: allowed ± deviation, in cycles, from each nominal duration.
- T_GREEN_RED (derived), GREEN_RED_ms*CLK_FREQ/1000: nominal green phase length in cycles.
- T_YELLOW (derived), YELLOW_ms*CLK_FREQ/1000: nominal yellow phase length in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- NS_red, NS_yellow, NS_green  in  1 each  observed North-South lamps.
- EW_red, EW_yellow, EW_green  in  1 each  observed East-West lamps.
- fault_clr  in  1  single-cycle pulse that clears a latched fault.
- phase  out  2  decoded phase: 00 NS_GREEN, 01 NS_YELLOW, 10 EW_GREEN, 11 EW_YELLOW.
- phase_valid  out  1  lamp pattern decodes to a legal phase.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first fault cause: 0 none, 1 conflict, 2 invalid pattern, 3 bad sequence, 4 phase too short, 5 phase too long.
- cycle_count  out  16  count of completed full cycles (EW_YELLOW→NS_GREEN); wraps at 16 bits.

## Operation
- Lamp inputs are registered once (lamp_q). All decode and checks use lamp_q.
- Decode rules:
  - Each legal phase has exactly one lamp on per direction, in one of the four legal combinations.
  - Conflict: both directions show a non-red lamp (green or yellow).
  - Invalid: any other pattern, including all-dark and multiple lamps in one direction.
- Duration counter (32 bit, saturating):
  - Resets to 1 on each phase change.
  - Otherwise increments while the phase is stable.
- State machine:
  - MON_IDLE: waits for the first valid phase. Then loads that phase as the current phase, sets the counter to 1, and goes to MON_TRACK. No checks run in this state.
  - MON_TRACK, checks evaluated each cycle, in priority order:
    - conflict → code 1;
    - invalid → 2;
    - on phase change, the new phase is not the successor of the previous one (NSG→NSY→EWG→EWY→NSG) → 3;
    - on phase change, the ended phase lasted fewer than T−TOL_CYCLES cycles → 4 (skipped for the first phase after MON_IDLE);
    - counter exceeds T+TOL_CYCLES while the phase is still stable → 5, raised immediately without waiting for the phase to end.
  - Any check hit latches fault=1 and fault_code, and moves to MON_FAULT.
  - MON_FAULT: checks are frozen and fault_code holds the first cause. fault_clr clears fault and fault_code and returns to MON_IDLE.
- Per-phase nominal T: T_GREEN_RED for green phases, T_YELLOW for yellow phases.
- Simultaneous events:
  - Detection in the same cycle as fault_clr: the detection wins, fault stays 1, and fault_code takes the new cause.
  - fault_clr outside MON_FAULT: ignored.
- phase and phase_valid track the decode in every state.
- cycle_count increments on each legal EWY→NSG change in MON_TRACK.

## Timing
- Reset (asynchronous assert, synchronous release): state MON_IDLE; lamp_q=0; phase=00; phase_valid=0; fault=0; fault_code=0; cycle_count=0; counter=0.
- Latency: lamp change at the input → phase/phase_valid update 2 cycles later (1 input register plus 1 output register).
- Latency: fault asserts 2 cycles after the offending input pattern. A too-long fault asserts on the cycle in which the counter reaches T+TOL_CYCLES+1.
- A phase held exactly N cycles at the controller produces counter=N at the transition. N in [T−TOL, T+TOL] passes.
- Reset mid-operation: all state is lost and the monitor re-enters MON_IDLE. The first partial phase is never flagged as too short.

## Configuration
- INTERSECTION_MONITOR_DURATION_CHECK_EN
  - Defined: codes 4 and 5 are active and the duration counter is built.
  - Undefined: the counter and duration comparators are omitted. Only codes 1–3 can fire; cycle_count and sequence tracking are unchanged.

## Test plan
All scenarios use CLK_FREQ=1000, GREEN_RED_ms=10, YELLOW_ms=4, TOL_CYCLES=1, so T_GREEN_RED=10 and T_YELLOW=4.
- Nominal: drive a legal 10/4/10/4 sequence for 3 cycles → fault=0 throughout, cycle_count=3, and phase steps 00,01,10,11 with 2-cycle latency.
- Conflict: during NS_GREEN, also set EW_green=1 → fault=1, fault_code=1 two cycles later. fault_clr with clean lamps → fault=0 and state MON_IDLE.
- Sequence: NS_GREEN (10 cycles) jumps directly to EW_GREEN → fault_code=3.
- Duration: NS_YELLOW held 2 cycles → fault_code=4. In a separate run, EW_GREEN held 12+ cycles → fault_code=5 asserted while still green.
- Boundaries: green phases of 9 and 11 cycles → no fault. Dark pattern (all lamps 0) → fault_code=2. With the macro undefined, the 2-cycle yellow → no fault.
- Priority and reset: fault_clr pulsed in the same cycle as a new conflict → fault stays 1 with code 1. rst_n asserted mid-phase → all outputs 0 immediately, with no too-short fault afterwards.

Source files
------------

// File: rtl/intersection_monitor_if.sv
// Lamp bus observed by the intersection monitor, plus its fault/phase report.
// master = controller/supervisor side, slave = the monitor.
interface intersection_monitor_if;
  logic        NS_red;
  logic        NS_yellow;
  logic        NS_green;
  logic        EW_red;
  logic        EW_yellow;
  logic        EW_green;
  logic        fault_clr;
  logic [1:0]  phase;
  logic        phase_valid;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_count;

  modport master (
    output NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, fault_clr,
    input  phase, phase_valid, fault, fault_code, cycle_count
  );

  modport slave (
    input  NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, fault_clr,
    output phase, phase_valid, fault, fault_code, cycle_count
  );
endinterface

// File: rtl/intersection_monitor.sv
// Passive checker for the intersection lamp bus: decodes phase, checks sequence and
// durations, latches the first fault. Duration checks: INTERSECTION_MONITOR_DURATION_CHECK_EN.
module intersection_monitor #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned GREEN_RED_ms = 200,
  parameter int unsigned YELLOW_ms    = 40,
  parameter int unsigned TOL_CYCLES   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  intersection_monitor_if.slave mon
);
  // 64-bit intermediates: ms * Hz overflows 32 bits at the default clock
  localparam logic [63:0]  T_GREEN_RED_L = 64'(GREEN_RED_ms) * 64'(CLK_FREQ) / 64'd1000;
  localparam logic [63:0]  T_YELLOW_L    = 64'(YELLOW_ms) * 64'(CLK_FREQ) / 64'd1000;
  localparam int unsigned  T_GREEN_RED   = 32'(T_GREEN_RED_L);
  localparam int unsigned  T_YELLOW      = 32'(T_YELLOW_L);
  localparam int unsigned  CYC_W         = 16;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_INVALID  = 3'd2;
  localparam logic [2:0] CODE_SEQ      = 3'd3;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
  localparam int unsigned CNT_W      = 32;
  localparam logic [2:0]  CODE_SHORT = 3'd4;
  localparam logic [2:0]  CODE_LONG  = 3'd5;
  localparam logic [CNT_W-1:0] G_MIN = 32'(T_GREEN_RED - TOL_CYCLES);
  localparam logic [CNT_W-1:0] G_MAX = 32'(T_GREEN_RED + TOL_CYCLES);
  localparam logic [CNT_W-1:0] Y_MIN = 32'(T_YELLOW - TOL_CYCLES);
  localparam logic [CNT_W-1:0] Y_MAX = 32'(T_YELLOW + TOL_CYCLES);
`endif

  if (TOL_CYCLES >= T_YELLOW || TOL_CYCLES >= T_GREEN_RED) begin : g_tol_guard
    $error("intersection_monitor: TOL_CYCLES must be smaller than both nominal durations");
  end

  typedef enum logic [1:0] {MON_IDLE, MON_TRACK, MON_FAULT} state_e;
  typedef enum logic [1:0] {
    PH_NS_GREEN  = 2'b00,
    PH_NS_YELLOW = 2'b01,
    PH_EW_GREEN  = 2'b10,
    PH_EW_YELLOW = 2'b11
  } phase_e;

  state_e             state_q, state_d;
  phase_e             cur_q, cur_d;
  logic [5:0]         lamp_q;
  logic [1:0]         phase_q;
  logic               phase_valid_q;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   t_min_c, t_max_c;
`endif

  phase_e     dec_phase_c, succ_c;
  logic       dec_valid_c, conflict_c, changed_c;
  logic [2:0] hit_c;

  // Decode the registered lamp pattern: {NS r,y,g, EW r,y,g}
  always_comb begin
    dec_valid_c = 1'b1;
    dec_phase_c = PH_NS_GREEN;
    case (lamp_q)
      6'b001_100: dec_phase_c = PH_NS_GREEN;
      6'b010_100: dec_phase_c = PH_NS_YELLOW;
      6'b100_001: dec_phase_c = PH_EW_GREEN;
      6'b100_010: dec_phase_c = PH_EW_YELLOW;
      default:    dec_valid_c = 1'b0;
    endcase
  end

  assign conflict_c = (lamp_q[4] | lamp_q[3]) & (lamp_q[1] | lamp_q[0]);
  assign changed_c  = dec_valid_c && (dec_phase_c != cur_q);
  assign succ_c     = phase_e'(2'(cur_q + 2'd1));
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
  assign t_min_c = cur_q[0] ? Y_MIN : G_MIN;
  assign t_max_c = cur_q[0] ? Y_MAX : G_MAX;
`endif

  // Tracking checks in priority order; the first hit is the reported cause
  always_comb begin
    hit_c = CODE_NONE;
    if (conflict_c) begin
      hit_c = CODE_CONFLICT;
    end else if (!dec_valid_c) begin
      hit_c = CODE_INVALID;
    end else if (changed_c && (dec_phase_c != succ_c)) begin
      hit_c = CODE_SEQ;
    end
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
    else if (changed_c && !first_q && (cnt_q < t_min_c)) begin
      hit_c = CODE_SHORT;
    end else if (!changed_c && (cnt_q >= t_max_c)) begin
      hit_c = CODE_LONG;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    fault_d = fault_q;
    code_d  = code_q;
    cyc_d   = cyc_q;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
    cnt_d   = cnt_q;
    first_d = first_q;
`endif
    case (state_q)
      MON_IDLE: begin
        if (dec_valid_c) begin
          state_d = MON_TRACK;
          cur_d   = dec_phase_c;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
          cnt_d   = 32'd1;
          first_d = 1'b1;
`endif
        end
      end
      MON_TRACK: begin
        if (hit_c != CODE_NONE) begin
          state_d = MON_FAULT;
          fault_d = 1'b1;
          code_d  = hit_c;
        end else if (changed_c) begin
          cur_d = dec_phase_c;
          if (cur_q == PH_EW_YELLOW) begin
            cyc_d = cyc_q + 16'd1;
          end
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
          cnt_d   = 32'd1;
          first_d = 1'b0;
`endif
        end
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      MON_FAULT: begin
        // A pattern fault seen on the clearing cycle wins over the clear
        if (mon.fault_clr) begin
          if (conflict_c) begin
            code_d = CODE_CONFLICT;
          end else if (!dec_valid_c) begin
            code_d = CODE_INVALID;
          end else begin
            state_d = MON_IDLE;
            fault_d = 1'b0;
            code_d  = CODE_NONE;
          end
        end
      end
      default: state_d = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MON_IDLE;
      cur_q         <= PH_NS_GREEN;
      lamp_q        <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      code_q        <= CODE_NONE;
      cyc_q         <= '0;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
      cnt_q         <= '0;
      first_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      lamp_q        <= {mon.NS_red, mon.NS_yellow, mon.NS_green,
                        mon.EW_red, mon.EW_yellow, mon.EW_green};
      phase_valid_q <= dec_valid_c;
      if (dec_valid_c) begin
        phase_q <= dec_phase_c;
      end
      fault_q       <= fault_d;
      code_q        <= code_d;
      cyc_q         <= cyc_d;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
      cnt_q         <= cnt_d;
      first_q       <= first_d;
`endif
    end
  end

  assign mon.phase       = phase_q;
  assign mon.phase_valid = phase_valid_q;
  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.cycle_count = cyc_q;
endmodule

// File: tb/tb_intersection_monitor.sv
// Bench for intersection_monitor: directed vector table plus randomized lamp traffic
// checked every cycle against a rule-level reference model.
module tb_intersection_monitor;
  localparam int CLK_FREQ     = 1000;
  localparam int GREEN_RED_MS = 10;
  localparam int YELLOW_MS    = 4;
  localparam int TOL          = 1;
  localparam int TG           = GREEN_RED_MS * CLK_FREQ / 1000;
  localparam int TY           = YELLOW_MS * CLK_FREQ / 1000;
`ifdef INTERSECTION_MONITOR_DURATION_CHECK_EN
  localparam bit DUR_EN = 1'b1;
`else
  localparam bit DUR_EN = 1'b0;
`endif

  // {NS r,y,g, EW r,y,g}
  localparam logic [5:0] P_NSG  = 6'b001_100;
  localparam logic [5:0] P_NSY  = 6'b010_100;
  localparam logic [5:0] P_EWG  = 6'b100_001;
  localparam logic [5:0] P_EWY  = 6'b100_010;
  localparam logic [5:0] P_DARK = 6'b000_000;
  localparam logic [5:0] P_CONF = 6'b001_001;

  typedef struct {
    logic [5:0] lamps;
    int         hold;
    bit         clr;
    bit         rst;
    bit         fault;
    int         code;
    bit         valid;
    int         phase;
    int         cyc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[$];
  logic [5:0] legal [4];

  // Reference model state
  logic [5:0] m_lq;
  bit m_tracking, m_fault, m_first, m_valid;
  int m_code, m_cur, m_len, m_phase, m_cyc;

  intersection_monitor_if bus ();

  intersection_monitor #(
    .CLK_FREQ    (CLK_FREQ),
    .GREEN_RED_ms(GREEN_RED_MS),
    .YELLOW_ms   (YELLOW_MS),
    .TOL_CYCLES  (TOL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int nominal(input int p);
    return (p % 2 == 0) ? TG : TY;
  endfunction

  // 0..3 legal phase, 4 conflict, 5 any other pattern
  function automatic int classify(input logic [5:0] l);
    for (int p = 0; p < 4; p++) if (l == legal[p]) return p;
    if ((l[4] | l[3]) && (l[1] | l[0])) return 4;
    return 5;
  endfunction

  function automatic void model_reset();
    m_lq = '0; m_tracking = 0; m_fault = 0; m_first = 0; m_valid = 0;
    m_code = 0; m_cur = 0; m_len = 0; m_phase = 0; m_cyc = 0;
  endfunction

  // One clock of the monitor rules applied to the previously sampled pattern
  function automatic void model_step(input bit clr);
    int k = classify(m_lq);
    int code = 0;
    if (m_fault) begin
      if (clr) begin
        if (k == 4) m_code = 1;
        else if (k == 5) m_code = 2;
        else begin m_fault = 0; m_code = 0; m_tracking = 0; end
      end
    end else if (!m_tracking) begin
      if (k < 4) begin m_tracking = 1; m_cur = k; m_len = 1; m_first = 1; end
    end else begin
      if (k == 4) code = 1;
      else if (k == 5) code = 2;
      else if (k != m_cur) begin
        if (k != (m_cur + 1) % 4) code = 3;
        else if (DUR_EN && !m_first && m_len < nominal(m_cur) - TOL) code = 4;
      end else if (DUR_EN && m_len + 1 > nominal(m_cur) + TOL) code = 5;
      if (code != 0) begin
        m_fault = 1; m_code = code; m_tracking = 0;
      end else if (k != m_cur) begin
        if (m_cur == 3 && k == 0) m_cyc = (m_cyc + 1) % 65536;
        m_cur = k; m_len = 1; m_first = 0;
      end else m_len++;
    end
    m_valid = (k < 4);
    if (k < 4) m_phase = k;
  endfunction

  task automatic drive(input logic [5:0] l);
    {bus.NS_red, bus.NS_yellow, bus.NS_green, bus.EW_red, bus.EW_yellow, bus.EW_green} = l;
  endtask

  task automatic tick(input logic [5:0] l, input bit clr);
    drive(l);
    bus.fault_clr = clr;
    @(posedge clk);
    model_step(clr);
    m_lq = l;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    check("model fault", 32'(bus.fault), 32'(m_fault));
    check("model fault_code", 32'(bus.fault_code), 32'(m_code));
    check("model phase_valid", 32'(bus.phase_valid), 32'(m_valid));
    check("model phase", 32'(bus.phase), 32'(m_phase));
    check("model cycle_count", 32'(bus.cycle_count), 32'(m_cyc));
  endtask

  // Asynchronous assert (outputs must clear before any clock edge), release at negedge
  task automatic do_reset(input int n);
    drive(P_DARK);
    bus.fault_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset fault", 32'(bus.fault), 32'd0);
    check("reset fault_code", 32'(bus.fault_code), 32'd0);
    check("reset phase", 32'(bus.phase), 32'd0);
    check("reset phase_valid", 32'(bus.phase_valid), 32'd0);
    check("reset cycle_count", 32'(bus.cycle_count), 32'd0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic void add(input logic [5:0] l, input int hold, input bit clr, input bit rst,
                              input bit f, input int code, input bit v, input int ph, input int cyc);
    vec_t e;
    e.lamps = l; e.hold = hold; e.clr = clr; e.rst = rst; e.fault = f;
    e.code = code; e.valid = v; e.phase = ph; e.cyc = cyc;
    vecs.push_back(e);
  endfunction

  function automatic void add_rst();
    add(P_DARK, 2, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    logic [5:0] l;
    int n, r, nx, idx;
    bit clr;

    legal[0] = P_NSG; legal[1] = P_NSY; legal[2] = P_EWG; legal[3] = P_EWY;
    drive(P_DARK);
    bus.fault_clr = 1'b0;
    model_reset();

    // Nominal: three full 10/4/10/4 cycles
    add_rst();
    for (int c = 0; c < 3; c++) begin
      add(P_NSG, 10, 0, 0, 0, 0, 1, 0, c);
      add(P_NSY, 4, 0, 0, 0, 0, 1, 1, c);
      add(P_EWG, 10, 0, 0, 0, 0, 1, 2, c);
      add(P_EWY, 4, 0, 0, 0, 0, 1, 3, c);
    end
    add(P_NSG, 2, 0, 0, 0, 0, 1, 0, 3);
    // Conflict, then clear with clean lamps
    add_rst();
    add(P_NSG, 5, 0, 0, 0, 0, 1, 0, 0);
    add(P_CONF, 2, 0, 0, 1, 1, 0, 0, 0);
    add(P_NSG, 2, 1, 0, 0, 0, 1, 0, 0);
    add(P_NSG, 3, 0, 0, 0, 0, 1, 0, 0);
    // Sequence skip NSG -> EWG
    add_rst();
    add(P_NSG, 10, 0, 0, 0, 0, 1, 0, 0);
    add(P_EWG, 2, 0, 0, 1, 3, 1, 2, 0);
    // Short yellow
    add_rst();
    add(P_NSG, 10, 0, 0, 0, 0, 1, 0, 0);
    add(P_NSY, 2, 0, 0, 0, 0, 1, 1, 0);
    add(P_EWG, 2, 0, 0, DUR_EN, DUR_EN ? 4 : 0, 1, 2, 0);
    // Long green: 12th cycle still fine at the output, fault one cycle later
    add_rst();
    add(P_NSG, 10, 0, 0, 0, 0, 1, 0, 0);
    add(P_NSY, 4, 0, 0, 0, 0, 1, 1, 0);
    add(P_EWG, 12, 0, 0, 0, 0, 1, 2, 0);
    add(P_EWG, 1, 0, 0, DUR_EN, DUR_EN ? 5 : 0, 1, 2, 0);
    // Boundaries 9 and 11, then dark
    add_rst();
    add(P_NSG, 10, 0, 0, 0, 0, 1, 0, 0);
    add(P_NSY, 4, 0, 0, 0, 0, 1, 1, 0);
    add(P_EWG, 9, 0, 0, 0, 0, 1, 2, 0);
    add(P_EWY, 4, 0, 0, 0, 0, 1, 3, 0);
    add(P_NSG, 11, 0, 0, 0, 0, 1, 0, 1);
    add(P_NSY, 4, 0, 0, 0, 0, 1, 1, 1);
    add(P_EWG, 11, 0, 0, 0, 0, 1, 2, 1);
    add(P_EWY, 2, 0, 0, 0, 0, 1, 3, 1);
    add(P_DARK, 2, 0, 0, 1, 2, 0, 0, 1);
    // Clear coinciding with a fresh conflict: conflict wins
    add(P_CONF, 2, 1, 0, 1, 1, 0, 0, 1);
    // Clean clear keeps cycle_count, then reset mid-phase and a short first phase
    add(P_NSG, 2, 1, 0, 0, 0, 1, 0, 1);
    add(P_NSG, 3, 0, 0, 0, 0, 1, 0, 1);
    add_rst();
    add(P_NSY, 2, 0, 0, 0, 0, 1, 1, 0);
    add(P_EWG, 3, 0, 0, 0, 0, 1, 2, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].hold);
      else for (int t = 0; t < vecs[i].hold; t++) tick(vecs[i].lamps, vecs[i].clr && (t == vecs[i].hold - 1));
      check($sformatf("vec%0d fault", i), 32'(bus.fault), 32'(vecs[i].fault));
      check($sformatf("vec%0d fault_code", i), 32'(bus.fault_code), 32'(vecs[i].code));
      check($sformatf("vec%0d phase_valid", i), 32'(bus.phase_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d cycle_count", i), 32'(bus.cycle_count), 32'(vecs[i].cyc));
      if (vecs[i].valid || vecs[i].rst)
        check($sformatf("vec%0d phase", i), 32'(bus.phase), 32'(vecs[i].phase));
    end

    // Randomized traffic: mostly legal phases with jittered durations, some faults and clears
    do_reset(2);
    nx = 0;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 15) begin
        l  = legal[nx];
        n  = nominal(nx) + int'($urandom_range(0, 4)) - 2;
        nx = (nx + 1) % 4;
      end else begin
        if (r == 15) begin
          idx = int'($urandom_range(0, 3));
          l = legal[idx];
        end else if (r == 16) l = P_DARK;
        else if (r == 17) l = P_CONF;
        else l = 6'($urandom_range(0, 63));
        n = int'($urandom_range(1, 3));
      end
      for (int t = 0; t < n; t++) begin
        clr = (m_fault && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 40) == 0);
        tick(l, clr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
